// File: rtl/ddr2_app_arbiter.sv
// ---------------------------------------------------------------------------
// ddr2_app_arbiter
//
// Shares the single MIG DDR2 application interface between one write
// requester and one read requester. Each held request is granted, turned
// into a correctly handshaked MIG command and acknowledged with a
// one-cycle pulse. A write command is issued together with its single data
// beat. The read-return path registers MIG read data and tracks the number
// of reads in flight, so reads stall once MAX_RD_OUT are outstanding.
//
// Ports
//   clk_in              ui_clk; all logic on the rising edge
//   rst                 asynchronous active-high reset (ui_clk_sync_rst)
//   init_calib_complete MIG calibration done; no grants until it is high
//   wr_req/wr_addr/wr_data  write request, held until wr_ack
//   wr_ack              1-cycle pulse: command and data both taken by MIG
//   rd_req/rd_addr      read request, held until rd_ack
//   rd_ack              1-cycle pulse: read command taken by MIG
//   rd_data/rd_valid    app_rd_data/app_rd_data_valid delayed one cycle
//   rd_outstanding      reads issued but not yet returned
//   app_*               MIG user interface (command, write data, read data)
// ---------------------------------------------------------------------------
module ddr2_app_arbiter #(
    parameter int ADDR_W     = 27,
    parameter int DATA_W     = 128,
    parameter int MAX_BURST  = 8,
    parameter int MAX_RD_OUT = 16
) (
    input  logic                              clk_in,
    input  logic                              rst,
    input  logic                              init_calib_complete,
    input  logic                              wr_req,
    input  logic [ADDR_W-1:0]                 wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic                              wr_ack,
    input  logic                              rd_req,
    input  logic [ADDR_W-1:0]                 rd_addr,
    output logic                              rd_ack,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              rd_valid,
    output logic [$clog2(MAX_RD_OUT+1)-1:0]   rd_outstanding,
    output logic                              app_en,
    output logic [2:0]                        app_cmd,
    output logic [ADDR_W-1:0]                 app_addr,
    output logic [DATA_W-1:0]                 app_wdf_data,
    output logic                              app_wdf_wren,
    output logic                              app_wdf_end,
    input  logic                              app_rdy,
    input  logic                              app_wdf_rdy,
    input  logic [DATA_W-1:0]                 app_rd_data,
    input  logic                              app_rd_data_valid
);

    localparam int CNT_W   = $clog2(MAX_RD_OUT + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [CNT_W-1:0]   RD_LIMIT    = CNT_W'(MAX_RD_OUT);
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        WAIT_CAL = 2'd0,
        IDLE     = 2'd1,
        WR_ISSUE = 2'd2,
        RD_ISSUE = 2'd3
    } state_t;

    typedef enum logic {
        SIDE_WR = 1'b0,
        SIDE_RD = 1'b1
    } side_t;

    state_t              state_reg, state_next;
    side_t               last_grant, last_grant_next;
    logic [BURST_W-1:0]  burst_cnt, burst_cnt_next;

    logic                app_en_next;
    logic [2:0]          app_cmd_next;
    logic [ADDR_W-1:0]   app_addr_next;
    logic [DATA_W-1:0]   app_wdf_data_next;
    logic                app_wdf_wren_next;
    logic                wr_ack_next;
    logic                rd_ack_next;
    logic [CNT_W-1:0]    rd_outstanding_next;
    logic                rd_issued;

    logic                wr_eligible;
    logic                rd_eligible;
    logic                grant_wr;
    logic                grant_rd;
    logic                keep_last;

    // A requester is masked in its own ack cycle: it still holds the request
    // it has just been served for.
    assign wr_eligible = wr_req && !wr_ack;
    assign rd_eligible = rd_req && !rd_ack && (rd_outstanding < RD_LIMIT);

    // Contention: stay with last_grant while a burst is running and under
    // its limit. burst_cnt is 0 only before the first grant after reset; in
    // that case the side opposite last_grant (write) wins.
    assign keep_last = (burst_cnt != '0) && (burst_cnt < BURST_LIMIT);

    always_comb begin : grant_select
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (wr_eligible && rd_eligible) begin
            if (keep_last) begin
                grant_wr = (last_grant == SIDE_WR);
            end else begin
                grant_wr = (last_grant == SIDE_RD);
            end
            grant_rd = !grant_wr;
        end else begin
            grant_wr = wr_eligible;
            grant_rd = rd_eligible;
        end
    end

    always_comb begin : fsm_next
        state_next        = state_reg;
        last_grant_next   = last_grant;
        burst_cnt_next    = burst_cnt;
        app_en_next       = app_en;
        app_cmd_next      = app_cmd;
        app_addr_next     = app_addr;
        app_wdf_data_next = app_wdf_data;
        app_wdf_wren_next = app_wdf_wren;
        wr_ack_next       = 1'b0;
        rd_ack_next       = 1'b0;
        rd_issued         = 1'b0;

        case (state_reg)
            WAIT_CAL: begin
                if (init_calib_complete) begin
                    state_next = IDLE;
                end
            end

            IDLE: begin
                if (!init_calib_complete) begin
                    state_next = WAIT_CAL;
                end else if (grant_wr || grant_rd) begin
                    // Burst bookkeeping: saturate so a long single-sided run
                    // cannot wrap the counter back below the limit.
                    if ((grant_wr && last_grant == SIDE_WR) ||
                        (grant_rd && last_grant == SIDE_RD)) begin
                        if (burst_cnt != BURST_LIMIT) begin
                            burst_cnt_next = burst_cnt + BURST_W'(1);
                        end
                    end else begin
                        burst_cnt_next  = BURST_W'(1);
                        last_grant_next = grant_wr ? SIDE_WR : SIDE_RD;
                    end

                    app_en_next = 1'b1;
                    if (grant_wr) begin
                        app_cmd_next      = CMD_WRITE;
                        app_addr_next     = wr_addr;
                        app_wdf_data_next = wr_data;
                        app_wdf_wren_next = 1'b1;
                        state_next        = WR_ISSUE;
                    end else begin
                        app_cmd_next  = CMD_READ;
                        app_addr_next = rd_addr;
                        state_next    = RD_ISSUE;
                    end
                end
            end

            WR_ISSUE: begin
                // Command and data handshakes retire independently; the ack
                // waits until both have been taken.
                if (app_rdy) begin
                    app_en_next = 1'b0;
                end
                if (app_wdf_rdy) begin
                    app_wdf_wren_next = 1'b0;
                end
                if ((!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy)) begin
                    wr_ack_next = 1'b1;
                    state_next  = IDLE;
                end
            end

            RD_ISSUE: begin
                if (app_rdy) begin
                    app_en_next = 1'b0;
                    rd_ack_next = 1'b1;
                    rd_issued   = 1'b1;
                    state_next  = IDLE;
                end
            end

            default: begin
                state_next = WAIT_CAL;
            end
        endcase
    end

    // In-flight read counter. A return with nothing outstanding is a
    // protocol error from the MIG side and is ignored (saturate at 0).
    always_comb begin : outstanding_next
        rd_outstanding_next = rd_outstanding;
        if (rd_issued && !(app_rd_data_valid && rd_outstanding != '0)) begin
            rd_outstanding_next = rd_outstanding + CNT_W'(1);
        end else if (!rd_issued && app_rd_data_valid && rd_outstanding != '0) begin
            rd_outstanding_next = rd_outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg      <= WAIT_CAL;
            last_grant     <= SIDE_RD;
            burst_cnt      <= '0;
            app_en         <= 1'b0;
            app_cmd        <= CMD_READ;
            app_addr       <= '0;
            app_wdf_data   <= '0;
            app_wdf_wren   <= 1'b0;
            app_wdf_end    <= 1'b0;
            wr_ack         <= 1'b0;
            rd_ack         <= 1'b0;
            rd_data        <= '0;
            rd_valid       <= 1'b0;
            rd_outstanding <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant     <= last_grant_next;
            burst_cnt      <= burst_cnt_next;
            app_en         <= app_en_next;
            app_cmd        <= app_cmd_next;
            app_addr       <= app_addr_next;
            app_wdf_data   <= app_wdf_data_next;
            // Single-beat writes: the end marker always tracks wren.
            app_wdf_wren   <= app_wdf_wren_next;
            app_wdf_end    <= app_wdf_wren_next;
            wr_ack         <= wr_ack_next;
            rd_ack         <= rd_ack_next;
            rd_data        <= app_rd_data;
            rd_valid       <= app_rd_data_valid;
            rd_outstanding <= rd_outstanding_next;
        end
    end

endmodule

// File: tb/tb_ddr2_app_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr2_app_arbiter
//
// Directed bench for ddr2_app_arbiter. A transaction-level model (grant
// history queue, in-flight read count, per-command pending flags) predicts
// every registered output each cycle; a compare process checks the DUT one
// time unit after each rising edge. Directed scenarios add hand-computed
// literal expectations (latencies, pulse widths, burst run lengths, read
// stall counts, reissue after reset).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ddr2_app_arbiter;

    localparam int ADDR_W     = 27;
    localparam int DATA_W     = 128;
    localparam int MAX_BURST  = 8;
    localparam int MAX_RD_OUT = 16;
    localparam int CNT_W      = $clog2(MAX_RD_OUT + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              init_calib_complete = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ack;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_outstanding;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic [DATA_W-1:0] app_wdf_data;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_rdy = 1'b1;
    logic              app_wdf_rdy = 1'b1;
    logic [DATA_W-1:0] app_rd_data = '0;
    logic              app_rd_data_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    ddr2_app_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_BURST(MAX_BURST), .MAX_RD_OUT(MAX_RD_OUT)
    ) dut (
        .clk_in(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_outstanding(rd_outstanding),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int                m_phase = 0;     // 0 await calibration, 1 idle, 2 write busy, 3 read busy
    bit                e_app_en = 0, e_wren = 0, e_wr_ack = 0, e_rd_ack = 0, e_rd_valid = 0;
    logic [2:0]        e_cmd = 3'b001;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_wdata = '0, e_rd_data = '0;
    int                e_out = 0;
    bit                hist[$];         // 1 = write grant, 0 = read grant

    function automatic int run_len();
        int n = 0;
        if (hist.size() == 0) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[hist.size()-1]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_phase = 0; e_app_en = 0; e_wren = 0; e_wr_ack = 0; e_rd_ack = 0;
        e_rd_valid = 0; e_cmd = 3'b001; e_addr = '0; e_wdata = '0; e_rd_data = '0;
        e_out = 0; hist.delete();
    endtask

    task automatic model_step();
        bit o_en, o_wren, o_wack, o_rack, issued, we, re, pick_w, cd, dd;
        int o_out;
        o_en = e_app_en; o_wren = e_wren; o_wack = e_wr_ack; o_rack = e_rd_ack;
        o_out = e_out; issued = 0; pick_w = 0;
        e_wr_ack = 0; e_rd_ack = 0;
        e_rd_valid = app_rd_data_valid; e_rd_data = app_rd_data;
        case (m_phase)
            0: if (init_calib_complete) m_phase = 1;
            1: begin
                if (!init_calib_complete) m_phase = 0;
                else begin
                    we = wr_req && !o_wack;
                    re = rd_req && !o_rack && (o_out < MAX_RD_OUT);
                    if (we && re) begin
                        if (hist.size() == 0) pick_w = 1;           // first contention: write
                        else if (run_len() < MAX_BURST) pick_w = hist[$];
                        else pick_w = !hist[$];
                    end else pick_w = we;
                    if (we || re) begin
                        hist.push_back(pick_w);
                        if (hist.size() > 32) void'(hist.pop_front());
                        e_app_en = 1;
                        if (pick_w) begin
                            e_cmd = 3'b000; e_addr = wr_addr; e_wdata = wr_data;
                            e_wren = 1; m_phase = 2;
                        end else begin
                            e_cmd = 3'b001; e_addr = rd_addr; m_phase = 3;
                        end
                    end
                end
            end
            2: begin
                cd = !o_en || app_rdy;
                dd = !o_wren || app_wdf_rdy;
                if (app_rdy) e_app_en = 0;
                if (app_wdf_rdy) e_wren = 0;
                if (cd && dd) begin e_wr_ack = 1; m_phase = 1; end
            end
            default: begin
                if (app_rdy) begin e_app_en = 0; e_rd_ack = 1; issued = 1; m_phase = 1; end
            end
        endcase
        e_out = o_out + (issued ? 1 : 0) - ((app_rd_data_valid && o_out > 0) ? 1 : 0);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("app_en", app_en, e_app_en);
            chk("app_wdf_wren", app_wdf_wren, e_wren);
            chk("app_wdf_end", app_wdf_end, e_wren);
            chk("wr_ack", wr_ack, e_wr_ack);
            chk("rd_ack", rd_ack, e_rd_ack);
            chk("rd_valid", rd_valid, e_rd_valid);
            chk("rd_data", rd_data, e_rd_data);
            chk("rd_outstanding", rd_outstanding, e_out);
            chk("app_cmd", app_cmd, e_cmd);
            chk("app_addr", app_addr, e_addr);
            chk("app_wdf_data", app_wdf_data, e_wdata);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one write. app_rdy / app_wdf_rdy are high during cycle c iff
    // c >= xr / xw, cycle 0 being the one in which the request is sampled.
    task automatic run_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                             input int xr, input int xw,
                             output int lat, output int en_cyc, output int wren_cyc,
                             output logic [2:0] cmd_seen, output logic [ADDR_W-1:0] addr_seen);
        bit got = 0;
        int extra = 0;
        wr_addr = addr; wr_data = data; wr_req = 1'b1;
        app_rdy = (0 >= xr); app_wdf_rdy = (0 >= xw);
        lat = 0; en_cyc = 0; wren_cyc = 0; cmd_seen = 3'b111; addr_seen = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            lat++;
            if (app_en) begin
                if (en_cyc == 0) begin cmd_seen = app_cmd; addr_seen = app_addr; end
                en_cyc++;
            end
            if (app_wdf_wren) wren_cyc++;
            if (wr_ack) got = 1;
            else begin app_rdy = (lat >= xr); app_wdf_rdy = (lat >= xw); end
        end
        chk("wr_ack_seen", got, 1'b1);
        wr_req = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wr_ack) extra++;
        end
        chk("wr_ack_single", extra, 0);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int lat, en_c, wren_c, cnt, acks, runs_checked, same_pairs;
        logic [2:0] cmd_s;
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] d;
        bit seq[$];
        bit got;

        // Reset and calibration gating.
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_app_cmd", app_cmd, 3'b001);
        chk("reset_outstanding", rd_outstanding, 0);
        chk("reset_app_en", app_en, 1'b0);
        wr_req = 1'b1; wr_addr = 27'h100; wr_data = {16{8'hA5}};
        cnt = 0;
        repeat (6) begin tick(); if (app_en) cnt++; end
        chk("no_grant_uncalibrated", cnt, 0);
        wr_req = 1'b0;
        init_calib_complete = 1'b1;
        repeat (3) tick();

        // Best-case single write.
        run_write(27'h100, {16{8'hA5}}, 0, 0, lat, en_c, wren_c, cmd_s, addr_s);
        chk("wr_best_latency", lat, 2);
        chk("wr_best_en_cycles", en_c, 1);
        chk("wr_best_wren_cycles", wren_c, 1);
        chk("wr_best_cmd", cmd_s, 3'b000);
        chk("wr_best_addr", addr_s, 27'h100);

        // Data accepted 3 cycles before the command.
        run_write(27'h104, {8{16'h1357}}, 4, 1, lat, en_c, wren_c, cmd_s, addr_s);
        chk("wr_data_first_latency", lat, 5);
        chk("wr_data_first_en", en_c, 4);
        chk("wr_data_first_wren", wren_c, 1);
        // Command accepted 3 cycles before the data.
        run_write(27'h108, {8{16'h2468}}, 1, 4, lat, en_c, wren_c, cmd_s, addr_s);
        chk("wr_cmd_first_latency", lat, 5);
        chk("wr_cmd_first_en", en_c, 1);
        chk("wr_cmd_first_wren", wren_c, 4);
        // Both accepted together after a stall.
        run_write(27'h10C, {8{16'hBEEF}}, 3, 3, lat, en_c, wren_c, cmd_s, addr_s);
        chk("wr_both_latency", lat, 4);
        chk("wr_both_en", en_c, 3);
        chk("wr_both_wren", wren_c, 3);

        // Contention every cycle the writer is not being acked: the reader
        // steps in only after MAX_BURST consecutive writes.
        app_rd_data_valid = 1'b1;
        wr_req = 1'b1; wr_addr = 27'h300; wr_data = {4{32'hCAFE_0001}};
        rd_req = 1'b1; rd_addr = 27'h40;
        for (int i = 0; i < 200; i++) begin
            tick();
            app_rd_data = {4{32'(i)}};
            if (wr_ack) seq.push_back(1'b1);
            if (rd_ack) seq.push_back(1'b0);
            rd_req = !wr_ack;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        repeat (4) tick();
        runs_checked = 0; cnt = -1;
        foreach (seq[i]) begin
            if (!seq[i]) begin
                if (cnt >= 0) begin chk("burst_run_length", cnt, MAX_BURST); runs_checked++; end
                cnt = 0;
            end else if (cnt >= 0) cnt++;
        end
        chk("burst_runs_seen", runs_checked >= 3, 1'b1);

        // Both held continuously: the other side is grantable in each ack
        // cycle, so grants strictly alternate.
        seq.delete();
        wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wr_ack) seq.push_back(1'b1);
            if (rd_ack) seq.push_back(1'b0);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        repeat (4) tick();
        same_pairs = 0;
        for (int i = 1; i < seq.size(); i++) if (seq[i] == seq[i-1]) same_pairs++;
        chk("alternate_same_pairs", same_pairs, 0);
        chk("alternate_grants", seq.size(), 20);
        repeat (4) tick();
        app_rd_data_valid = 1'b0;
        chk("drained_before_reads", rd_outstanding, 0);

        // Read stall at MAX_RD_OUT.
        rd_req = 1'b1; rd_addr = 27'h80; acks = 0;
        for (int i = 0; i < 80; i++) begin tick(); if (rd_ack) acks++; end
        chk("reads_before_stall", acks, 16);
        chk("outstanding_full", rd_outstanding, 16);
        d = {4{32'hDEAD_BEEF}};
        app_rd_data = d; app_rd_data_valid = 1'b1;
        tick();
        app_rd_data_valid = 1'b0;
        chk("return_rd_valid", rd_valid, 1'b1);
        chk("return_rd_data", rd_data, d);
        chk("return_outstanding", rd_outstanding, 15);
        acks = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (rd_ack) acks++; end
        chk("read_17_issued", acks, 1);
        chk("outstanding_refull", rd_outstanding, 16);
        app_rdy = 1'b0; app_rd_data_valid = 1'b1;
        tick();
        app_rd_data_valid = 1'b0;
        repeat (4) tick();
        chk("read_stalled_app_en", app_en, 1'b1);
        app_rdy = 1'b1; app_rd_data_valid = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("same_cycle_rd_ack", rd_ack, 1'b1);
        chk("same_cycle_outstanding", rd_outstanding, 15);
        repeat (15) tick();
        chk("drained_outstanding", rd_outstanding, 0);
        tick();
        chk("saturate_at_zero", rd_outstanding, 0);
        app_rd_data_valid = 1'b0;
        tick();

        // Reset in the middle of a stalled write.
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        wr_req = 1'b1; wr_addr = 27'h2A0; wr_data = {4{32'h1234_5678}};
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin tick(); if (app_en) got = 1; end
        chk("stall_write_started", got, 1'b1);
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_app_en", app_en, 1'b0);
        chk("rst_mid_wren", app_wdf_wren, 1'b0);
        chk("rst_mid_wr_ack", wr_ack, 1'b0);
        chk("rst_mid_app_cmd", app_cmd, 3'b001);
        chk("rst_mid_app_addr", app_addr, 0);
        chk("rst_mid_wdf_data", app_wdf_data, 0);
        repeat (2) tick();
        rst = 1'b0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        got = 0; addr_s = '0; d = '0; cnt = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (app_en && cnt == 0) begin addr_s = app_addr; d = app_wdf_data; cnt = 1; end
            if (wr_ack) got = 1;
        end
        wr_req = 1'b0;
        chk("reissue_ack", got, 1'b1);
        chk("reissue_addr", addr_s, 27'h2A0);
        chk("reissue_data", d, {4{32'h1234_5678}});
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
